// File: rtl/fxp_mult_fifo.sv
// Signed fixed-point multiplier / multiply-accumulator feeding a first-word-fall-through
// output FIFO. Pairs are popped from two operand sources, scaled by FRAC_BITS, optionally
// accumulated over ACC_LEN pairs, reduced to DATA_WIDTH bits and queued for the consumer.
module fxp_mult_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int FIFO_DEPTH = 256,
    parameter int ACC_LEN    = 1,
    parameter int ROUND      = 0,
    parameter int SATURATE   = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         ina,
    input  logic                          ina_empty,
    output logic                          ina_rd_en,
    input  logic [DATA_WIDTH-1:0]         inb,
    input  logic                          inb_empty,
    output logic                          inb_rd_en,
    input  logic                          mac_en,
    output logic [DATA_WIDTH-1:0]         out,
    output logic                          out_empty,
    input  logic                          out_rd_en,
    output logic [$clog2(FIFO_DEPTH):0]   out_count,
    output logic                          ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int PRD_W = 2 * DATA_WIDTH;
    localparam int ACC_W = PRD_W + $clog2(ACC_LEN) + 1;

    localparam logic signed [ACC_W-1:0] RND_C =
        (ROUND != 0) ? ({{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1)) : {ACC_W{1'b0}};
    localparam logic [DATA_WIDTH-1:0] MAX_C   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_C   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]      LAST_C  = CNT_W'(ACC_LEN - 1);
    localparam logic [PTR_W:0]        FULL_C  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     mode_q, mode_d;
    logic                     ovf_q, ovf_d;
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]           count_q;
    logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];

    logic signed [PRD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]  scaled_s, sum_s, final_s;
    logic [DATA_WIDTH-1:0]    reduced_s;
    logic                     fits_s, pop_s, full_s, wr_s, rd_s, mode_eff_s;

    // Datapath: full-width signed product, scaling, accumulation and reduction.
    always_comb begin
        prod_s     = $signed({{DATA_WIDTH{ina[DATA_WIDTH-1]}}, ina})
                   * $signed({{DATA_WIDTH{inb[DATA_WIDTH-1]}}, inb});
        scaled_s   = ($signed({{(ACC_W-PRD_W){prod_s[PRD_W-1]}}, prod_s}) + RND_C) >>> FRAC_BITS;
        sum_s      = acc_q + scaled_s;
        // The mode of a group is fixed by its first pair.
        mode_eff_s = (cnt_q == {CNT_W{1'b0}}) ? mac_en : mode_q;
        final_s    = mode_eff_s ? sum_s : scaled_s;
        // The value fits when every bit above the result sign bit matches it.
        fits_s     = (&final_s[ACC_W-1:DATA_WIDTH-1]) | ~(|final_s[ACC_W-1:DATA_WIDTH-1]);
        if (fits_s || (SATURATE == 0)) begin
            reduced_s = final_s[DATA_WIDTH-1:0];
        end else begin
            reduced_s = final_s[ACC_W-1] ? MIN_C : MAX_C;
        end
    end

    assign pop_s     = (state_q == IDLE) && !ina_empty && !inb_empty;
    assign full_s    = (count_q == FULL_C);
    assign wr_s      = (state_q == WRITE) && !full_s;
    assign rd_s      = out_rd_en && (count_q != {(PTR_W+1){1'b0}});
    assign ina_rd_en = pop_s && reset;
    assign inb_rd_en = pop_s && reset;

    // Next-state logic: accept pairs in IDLE, hand the held result to the FIFO in WRITE.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    mode_d = mode_eff_s;
                    if (!mode_eff_s || (cnt_q == LAST_C)) begin
                        result_d = reduced_s;
                        ovf_d    = ovf_q | ~fits_s;
                        acc_d    = {ACC_W{1'b0}};
                        cnt_d    = {CNT_W{1'b0}};
                        state_d  = WRITE;
                    end else begin
                        acc_d = sum_s;
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (!full_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WRITE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            result_q <= {DATA_WIDTH{1'b0}};
            acc_q    <= {ACC_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            mode_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; written only from WRITE while not full.
    always_ff @(posedge clock) begin
        if (reset && wr_s) begin
            mem_q[wr_ptr_q] <= result_q;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            if (wr_s) begin
                wr_ptr_q <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (rd_s) begin
                rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({wr_s, rd_s})
                2'b10:   count_q <= count_q + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{PTR_W{1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_empty = (count_q == {(PTR_W+1){1'b0}});
    assign out       = out_empty ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];
    assign out_count = count_q;
    assign ovf       = ovf_q;

endmodule
